// File: rtl/noc_types.sv
// Shared NoC types: flit layout, flit kinds and the sink FSM state encoding.
package noc_types;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        BODY = 2'd1,
        TAIL = 2'd2
    } flit_kind_t;

    typedef struct packed {
        flit_kind_t          kind;
        logic [ADDR_W-1:0]   dst;
        logic [DATA_W-1:0]   payload;
    } flit_t;

    typedef enum logic {
        IDLE      = 1'b0,
        CONNECTED = 1'b1
    } state_t;

endpackage

// File: rtl/node_port.sv
// Point-to-point link between an upstream sender and a downstream node port.
interface node_port;

    logic                enable;
    noc_types::flit_t    flit;
    logic                ack;
    logic                rej;

    modport up   (output enable, output flit, input  ack, input  rej);
    modport down (input  enable, input  flit, output ack, output rej);

endinterface

// File: rtl/noc_fifo.sv
// Synchronous FIFO with full/empty flags; a write into a full FIFO is taken when a read happens in the same cycle.
module noc_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              wr_ok;
    logic              rd_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && (!full || rd_en);
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; only pointers and occupancy are.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/node_port_sink.sv
// Packet sink for one NoC node: accepts a HEAD addressed to this node, buffers BODY/TAIL payloads for a local consumer.
module node_port_sink
    import noc_types::*;
#(
    parameter int NODE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    node_port.down            port,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              err,
    input  logic              err_clr
);

    localparam logic [ADDR_W-1:0] LOCAL_ADDR = ADDR_W'(NODE_ADDR);

    state_t state;
    state_t state_nxt;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push;
    logic push_last;
    logic rej_nxt;
    logic err_set;
    logic ack_q;
    logic rej_q;
    logic err_q;

    logic is_head;
    logic is_tail;
    logic head_ok;
    logic overflow;

    assign pop      = rd_valid && rd_ready;
    assign is_head  = (port.flit.kind == HEAD);
    assign is_tail  = (port.flit.kind == TAIL);
    assign head_ok  = (port.flit.dst == LOCAL_ADDR) && fifo_empty;
    // A full FIFO still takes a flit if the consumer frees a slot this cycle.
    assign overflow = fifo_full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (port.enable) begin
            case (state)
                IDLE: begin
                    if (is_head && head_ok) begin
                        state_nxt = CONNECTED;
                    end
                end
                CONNECTED: begin
                    if (is_head || overflow || is_tail) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        rej_nxt   = 1'b0;
        err_set   = 1'b0;
        if (port.enable) begin
            case (state)
                IDLE: begin
                    if (is_head) begin
                        rej_nxt = !head_ok;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                CONNECTED: begin
                    if (is_head || overflow) begin
                        rej_nxt = 1'b1;
                        err_set = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_last = is_tail;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and error flags are registered one cycle behind the sampled flit; set beats clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            rej_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= (state_nxt == CONNECTED);
            rej_q <= rej_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign port.ack = ack_q;
    assign port.rej = rej_q;
    assign err      = err_q;
    assign rd_valid = !fifo_empty;

    noc_fifo #(
        .DATA_W (DATA_W + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({push_last, port.flit.payload}),
        .rd_en   (pop),
        .rd_data ({rd_last, rd_data}),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_node_port_sink.sv
// Bench for node_port_sink at NODE_ADDR=3, FIFO_DEPTH=4: handshake checks plus a popped-entry scoreboard.
module tb_node_port_sink;
    import noc_types::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_valid;
    logic              rd_ready;
    logic              err;
    logic              err_clr;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W:0] sb [$];

    node_port port_if ();

    node_port_sink #(
        .NODE_ADDR  (3),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .port     (port_if),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .err      (err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input flit_kind_t k, input int d, input int p, input bit store);
        port_if.enable       = 1'b1;
        port_if.flit.kind    = k;
        port_if.flit.dst     = ADDR_W'(d);
        port_if.flit.payload = DATA_W'(p);
        if (store) sb.push_back({k == TAIL, DATA_W'(p)});
        step();
        port_if.enable = 1'b0;
    endtask

    task automatic drain(input int cycles);
        rd_ready = 1'b1;
        repeat (cycles) step();
        rd_ready = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    // Every entry leaving the FIFO is compared against the scoreboard front.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) begin
            if (sb.size() == 0) chk("sb_extra_pop", sb.size(), 1);
            else chk("rd_entry", {rd_last, rd_data}, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        rd_ready       = 1'b0;
        err_clr        = 1'b0;
        port_if.enable = 1'b0;
        port_if.flit   = '0;
        step();
        chk("rst_ack", port_if.ack, 0);
        chk("rst_rej", port_if.rej, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", rd_valid, 0);
        rst_n = 1'b1;
        step();

        // Normal packet with consumer always ready
        rd_ready = 1'b1;
        send(HEAD, 3, 0, 0);
        chk("pkt_ack_head", port_if.ack, 1);
        chk("pkt_head_not_stored", rd_valid, 0);
        send(BODY, 3, 8'hA1, 1);
        chk("pkt_ack_b1", port_if.ack, 1);
        send(BODY, 3, 8'hA2, 1);
        chk("pkt_ack_b2", port_if.ack, 1);
        send(TAIL, 3, 8'hA3, 1);
        chk("pkt_ack_after_tail", port_if.ack, 0);
        chk("pkt_err", err, 0);
        step();
        chk("pkt_drained", rd_valid, 0);
        rd_ready = 1'b0;

        // Address mismatch
        send(HEAD, 5, 0, 0);
        chk("miss_rej", port_if.rej, 1);
        chk("miss_ack", port_if.ack, 0);
        step();
        chk("miss_rej_pulse", port_if.rej, 0);
        chk("miss_ack2", port_if.ack, 0);
        chk("miss_empty", rd_valid, 0);
        chk("miss_err", err, 0);

        // Overflow with stalled consumer
        send(HEAD, 3, 0, 0);
        for (int i = 0; i < 4; i++) send(BODY, 3, 8'hB0 + i, 1);
        chk("ovf_no_rej", port_if.rej, 0);
        chk("ovf_ack_full", port_if.ack, 1);
        send(BODY, 3, 8'hB4, 0);
        chk("ovf_rej", port_if.rej, 1);
        chk("ovf_err", err, 1);
        chk("ovf_idle_ack", port_if.ack, 0);
        chk("ovf_kept", rd_valid, 1);
        step();
        chk("ovf_rej_pulse", port_if.rej, 0);
        chk("ovf_err_sticky", err, 1);
        clear_err();
        chk("ovf_err_clr", err, 0);
        drain(4);
        chk("ovf_drained", rd_valid, 0);

        // Full FIFO with simultaneous pop is not an overflow
        send(HEAD, 3, 0, 0);
        for (int i = 0; i < 4; i++) send(BODY, 3, 8'hC0 + i, 1);
        rd_ready = 1'b1;
        send(BODY, 3, 8'hC4, 1);
        rd_ready = 1'b0;
        chk("fullpop_rej", port_if.rej, 0);
        chk("fullpop_err", err, 0);
        chk("fullpop_ack", port_if.ack, 1);
        send(BODY, 3, 8'hC5, 0);
        chk("fullpop_count4_rej", port_if.rej, 1);
        chk("fullpop_count4_err", err, 1);
        clear_err();
        drain(4);
        chk("fullpop_drained", rd_valid, 0);

        // HEAD while previous packet still buffered, then retry after drain
        send(HEAD, 3, 0, 0);
        send(BODY, 3, 8'hD0, 1);
        send(TAIL, 3, 8'hD1, 1);
        send(HEAD, 3, 0, 0);
        chk("busy_rej", port_if.rej, 1);
        chk("busy_ack", port_if.ack, 0);
        chk("busy_err", err, 0);
        drain(2);
        chk("busy_drained", rd_valid, 0);
        send(HEAD, 3, 0, 0);
        chk("retry_ack", port_if.ack, 1);
        chk("retry_rej", port_if.rej, 0);
        send(TAIL, 3, 8'hD2, 1);
        chk("retry_tail_ack", port_if.ack, 0);
        drain(1);

        // HEAD while connected
        send(HEAD, 3, 0, 0);
        send(HEAD, 3, 0, 0);
        chk("dup_head_rej", port_if.rej, 1);
        chk("dup_head_err", err, 1);
        chk("dup_head_ack", port_if.ack, 0);
        clear_err();

        // Stray BODY in IDLE with simultaneous clear: set wins
        err_clr = 1'b1;
        send(BODY, 3, 8'hEE, 0);
        err_clr = 1'b0;
        chk("setclr_err", err, 1);
        chk("stray_no_rej", port_if.rej, 0);
        chk("stray_empty", rd_valid, 0);
        clear_err();
        chk("setclr_cleared", err, 0);

        // Reset mid-packet
        send(HEAD, 3, 0, 0);
        send(BODY, 3, 8'hE0, 0);
        send(BODY, 3, 8'hE1, 0);
        chk("prerst_valid", rd_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack", port_if.ack, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(BODY, 3, 8'hE2, 0);
        chk("postrst_err", err, 1);
        chk("postrst_ack", port_if.ack, 0);
        chk("postrst_rej", port_if.rej, 0);
        chk("postrst_empty", rd_valid, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/node_port_sink.md
NODE_PORT_SINK -- requirements
Module: node_port_sink

Interface
REQ-001 SHALL have parameter NODE_ADDR, default 0: local node address that HEAD flits are compared against.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of receive buffer entries; must be a power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port port, node_port.down modport: sampled flit/enable from upstream; ack/rej driven back upstream.
REQ-006 SHALL have port rd_data, output, noc_types::DATA_W: payload at FIFO head.
REQ-007 SHALL have port rd_last, output, 1: FIFO-head entry is the packet's TAIL.
REQ-008 SHALL have port rd_valid, output, 1: FIFO non-empty.
REQ-009 SHALL have port rd_ready, input, 1: consumer pops when rd_valid && rd_ready.
REQ-010 SHALL have port err, output, 1: sticky protocol/overflow error.
REQ-011 SHALL have port err_clr, input, 1: clears err (next cycle).

Function
REQ-012 SHALL use an FSM with states IDLE and CONNECTED.
REQ-013 SHALL register ack and rej: each responds the cycle after the sampled flit.
REQ-014 IDLE, enable && HEAD && dst==NODE_ADDR && FIFO empty: SHALL go to CONNECTED; ack=1 from next cycle; head flit not stored.
REQ-015 IDLE, enable && HEAD with dst mismatch or FIFO non-empty: SHALL pulse rej for exactly 1 cycle and stay IDLE; err unchanged.
REQ-016 IDLE, enable && BODY/TAIL: SHALL drop the flit and set err; no rej.
REQ-017 CONNECTED: SHALL hold ack=1 continuously.
REQ-018 CONNECTED, enable && BODY: SHALL push {payload, last=0}.
REQ-019 CONNECTED, enable && TAIL: SHALL push {payload, last=1} and go to IDLE; ack=0 from the cycle after the IDLE transition.
REQ-020 CONNECTED, enable && BODY/TAIL with FIFO full and no pop that cycle: SHALL drop the flit, pulse rej for 1 cycle, set err and go to IDLE. Entries already stored stay.
REQ-021 A push into a full FIFO with a simultaneous pop SHALL be accepted; it is not an overflow.
REQ-022 CONNECTED, enable && HEAD: SHALL pulse rej, set err and go to IDLE.
REQ-023 enable=0: SHALL change no FSM or FIFO state; flit is don't-care.
REQ-024 Pop SHALL be independent of the FSM; rd_* are valid combinationally from FIFO state.
REQ-025 Same-cycle err set and err_clr: set SHALL win.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, ack=0, rej=0, err=0 and FIFO empty (rd_valid=0).
REQ-028 Reset mid-packet SHALL discard the packet and all FIFO contents; the first post-reset flit is treated as in IDLE.

Structure
REQ-029 noc_types SHALL hold flit_t, flit_kind_t {HEAD, BODY, TAIL}, node address width, and DATA_W.
REQ-030 Storage SHALL be one sub-module noc_fifo: parameterized width/depth, synchronous, async active-low reset, with full/empty flags.
REQ-031 Only the FSM and ack/rej/err registers SHALL live in node_port_sink.

Verification
REQ-032 NODE_ADDR=3: HEAD dst=3, then BODY 0xA1, BODY 0xA2, TAIL 0xA3, rd_ready=1 -> ack high from cycle after HEAD through TAIL cycle; rd_data 0xA1, 0xA2, 0xA3; rd_last only on 0xA3.
REQ-033 HEAD dst=5 at NODE_ADDR=3 -> 1-cycle rej, ack never high, FIFO empty, err=0.
REQ-034 FIFO_DEPTH=4, rd_ready=0: HEAD plus 5 BODY -> 4 stored, rej on the cycle after the 5th, err=1, FSM IDLE; err_clr -> err=0.
REQ-035 Full FIFO with rd_ready=1 during a BODY push -> no rej, count stays 4.
REQ-036 Second HEAD dst=3 while the previous packet is still in the FIFO -> rej; after draining, the retried HEAD gets ack.
REQ-037 rst_n low for 1 cycle after 2 BODY flits -> ack=0, rd_valid=0 immediately; then BODY flit -> dropped, err=1.
